// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: funct3 sizes,
// FSM states and legality helpers used by the unit and its lane aligner.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Unsigned sizes exist only for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = !a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane logic: store byte enables / replicated write data,
// and load lane selection with sign or zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  a,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_be    = BE_ALL;
    st_wdata = wdata_in;
    case (f3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << a;
        st_wdata = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        st_be    = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rdata[{a, 3'b000} +: 8];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'd0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one req/ack bus transaction per
// EX/MEM instruction, stalling the pipeline until it completes or times out.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [2:0]        ex_f3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d, ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        a_q, a_d;

  logic        access, legal, stall_c;
  logic [2:0]  lane_f3;
  logic [1:0]  lane_a;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_ext;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^ex_addr[31:ADDR_W];

  assign access = ex_memread | ex_memwrite;
  assign legal  = f3_legal(ex_memwrite, ex_f3) && f3_aligned(ex_f3, ex_addr[1:0]);

  // IDLE shapes the outgoing store; WAIT extracts the returning load lane.
  assign lane_f3 = (state_q == ST_IDLE) ? ex_f3 : f3_q;
  assign lane_a  = (state_q == ST_IDLE) ? ex_addr[1:0] : a_q;

  mem_lane_align u_lane (
    .f3       (lane_f3),
    .a        (lane_a),
    .wdata_in (ex_wdata),
    .rdata    (dmem_rdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_data  (ld_ext)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = ld_valid_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    a_d        = a_q;
    stall_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ld_valid_d = 1'b0;
        if (access && !legal) begin
          misalign_d = 1'b1;
        end else if (access) begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = ex_memwrite;
          addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
          be_d    = ex_memwrite ? st_be : BE_ALL;
          wdata_d = ex_memwrite ? st_wdata : 32'd0;
          f3_d    = ex_f3;
          a_d     = ex_addr[1:0];
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            ld_data_d  = ld_ext;
            ld_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d      = 1'b0;
          bus_err_d  = 1'b1;
          ld_data_d  = 32'd0;
          ld_valid_d = 1'b0;
          state_d    = ST_DONE;
        end
      end
      default: begin
        ld_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      ld_data_q  <= 32'd0;
      ld_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      cnt_q      <= '0;
      f3_q       <= 3'd0;
      a_q        <= 2'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      a_q        <= a_d;
    end
  end

  assign stall      = stall_c & ~reset;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = ld_data_q;
  assign load_valid = ld_valid_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model sets the
// expected outputs per cycle, one negedge process compares them.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ex_memread = 1'b0, ex_memwrite = 1'b0;
  logic [2:0]        ex_f3 = 3'd0;
  logic [31:0]       ex_addr = 32'd0, ex_wdata = 32'd0, dmem_rdata = 32'd0;
  logic              dmem_ack = 1'b0;
  logic              dmem_req, dmem_we, stall, load_valid, misalign, bus_err;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata, load_data;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_f3(ex_f3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misalign(misalign), .bus_err(bus_err)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic              exp_stall, exp_req, exp_we, exp_lv, exp_mis, exp_berr, exp_zero;
  logic [ADDR_W-1:0] exp_addr;
  logic [3:0]        exp_be;
  logic [31:0]       exp_wdata, exp_ld;

  int                stall_cnt;
  bit                req_seen, mis_seen, berr_seen;
  logic [ADDR_W-1:0] cap_addr;
  logic [3:0]        cap_be;
  logic [31:0]       cap_wdata, cap_ld;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("dmem_req", 32'(dmem_req), 32'(exp_req));
      check("misalign", 32'(misalign), 32'(exp_mis));
      check("bus_err", 32'(bus_err), 32'(exp_berr));
      check("load_valid", 32'(load_valid), 32'(exp_lv));
      if (exp_req) begin
        check("dmem_we", 32'(dmem_we), 32'(exp_we));
        check("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
        check("dmem_be", 32'(dmem_be), 32'(exp_be));
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (exp_lv || exp_berr) check("load_data", load_data, exp_ld);
      if (exp_zero) begin
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", 32'(dmem_addr), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
      end
      if (stall) stall_cnt++;
      if (misalign) mis_seen = 1;
      if (bus_err) berr_seen = 1;
      if (dmem_req) begin
        req_seen  = 1;
        cap_addr  = dmem_addr;
        cap_be    = dmem_be;
        cap_wdata = dmem_wdata;
      end
      if (load_valid) cap_ld = load_data;
    end
  end

  // ---- transaction-level model ----
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    if (st && !(f3 inside {3'b000, 3'b001, 3'b010})) return 0;
    if (!st && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 0;
    return (addr % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = size_of(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int          sz = size_of(f3);
    logic [31:0] mask, v;
    if (sz == 4) return rdata;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (rdata >> (8 * (addr % 4))) & mask;
    if (f3[2] == 1'b0 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall = 0; exp_req = 0; exp_mis = 0; exp_berr = 0; exp_lv = 0; exp_zero = 0;
    exp_we = 0; exp_addr = '0; exp_be = 4'd0; exp_wdata = 32'd0; exp_ld = 32'd0;
  endtask

  task automatic set_wait_exp(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
    set_idle_exp();
    exp_stall = 1; exp_req = 1; exp_we = st;
    exp_addr  = ADDR_W'(addr & 32'hFFFF_FFFC);
    exp_be    = st ? m_be(f3, addr) : BE_ALL;
    exp_wdata = m_wdata(f3, wdata);
  endtask

  // One instruction from EX/MEM; ack_at = WAIT cycle carrying the ack, -1 for none.
  task automatic access(input string name, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_at);
    bit st = wr;
    bit ok = m_legal(st, f3, addr);
    bit acked = 0;
    stall_cnt = 0; req_seen = 0; mis_seen = 0; berr_seen = 0;
    ex_memread = rd; ex_memwrite = wr; ex_f3 = f3; ex_addr = addr; ex_wdata = wdata;
    dmem_ack = 0;
    set_idle_exp();
    exp_stall = ok;
    step();
    if (!ok) begin
      ex_memread = 0; ex_memwrite = 0;
      set_idle_exp();
      exp_mis = 1;
      step();
      $display("txn %s addr=0x%02h f3=%0d -> misaligned/illegal", name, addr[7:0], f3);
      return;
    end
    for (int w = 0; w < TIMEOUT; w++) begin
      dmem_ack   = (w == ack_at);
      dmem_rdata = (w == ack_at) ? rdata : $urandom;
      set_wait_exp(st, f3, addr, wdata);
      step();
      if (w == ack_at) begin
        acked = 1;
        break;
      end
    end
    dmem_ack = 0;
    set_idle_exp();
    exp_lv   = acked && !st;
    exp_berr = !acked;
    exp_ld   = acked ? m_load(f3, addr, rdata) : 32'd0;
    step();
    $display("txn %s addr=0x%02h f3=%0d we=%0d acked=%0d stall_cycles=%0d", name, addr[7:0],
             f3, st, acked, stall_cnt);
  endtask

  task automatic idle_cycle();
    ex_memread = 0; ex_memwrite = 0; dmem_ack = 0;
    set_idle_exp();
    step();
  endtask

  initial begin
    // Reset held with a pending load: nothing may start.
    reset = 1; ex_memread = 1; ex_f3 = F3_W; ex_addr = 32'h10;
    step();
    set_idle_exp(); exp_zero = 1; chk_en = 1;
    step();
    step();
    reset = 0;
    access("lw_after_reset", 1, 0, F3_W, 32'h10, 32'd0, 32'h1234_5678, 0);
    check("lit_lw_data", cap_ld, 32'h1234_5678);
    check("lit_lw_stall", stall_cnt, 2);

    access("sb", 0, 1, F3_B, 32'h07, 32'h0000_00A5, 32'd0, 2);
    check("lit_sb_addr", 32'(cap_addr), 32'h04);
    check("lit_sb_be", 32'(cap_be), 32'b1000);
    check("lit_sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    check("lit_sb_stall", stall_cnt, 4);

    access("lb", 1, 0, F3_B, 32'h12, 32'd0, 32'h0080_FF00, 0);
    check("lit_lb", cap_ld, 32'hFFFF_FF80);
    access("lbu", 1, 0, F3_BU, 32'h12, 32'd0, 32'h0080_FF00, 0);
    check("lit_lbu", cap_ld, 32'h0000_0080);

    access("lw_mis", 1, 0, F3_W, 32'h06, 32'd0, 32'd0, 0);
    check("lit_lw_mis_seen", 32'(mis_seen), 32'd1);
    check("lit_lw_mis_noreq", 32'(req_seen), 32'd0);
    check("lit_lw_mis_nostall", stall_cnt, 0);
    access("ld_f3_011", 1, 0, 3'b011, 32'h00, 32'd0, 32'd0, 0);
    check("lit_f3_011_mis", 32'(mis_seen), 32'd1);
    access("sbu_illegal", 0, 1, F3_BU, 32'h00, 32'd0, 32'd0, 0);
    access("sh_mis", 0, 1, F3_H, 32'h01, 32'd0, 32'd0, 0);

    access("lw_timeout", 1, 0, F3_W, 32'h20, 32'd0, 32'd0, -1);
    check("lit_to_berr", 32'(berr_seen), 32'd1);
    check("lit_to_stall", stall_cnt, 1 + TIMEOUT);

    // Ack on the last permitted WAIT cycle beats the timeout.
    access("lhu_late_ack", 1, 0, F3_HU, 32'h2A, 32'd0, 32'hBEEF_0000, TIMEOUT - 1);
    check("lit_lhu_late", cap_ld, 32'h0000_BEEF);
    check("lit_lhu_late_noberr", 32'(berr_seen), 32'd0);

    // Reset in the middle of a WAIT; a later ack must be ignored.
    ex_memread = 1; ex_memwrite = 0; ex_f3 = F3_W; ex_addr = 32'h40;
    set_idle_exp(); exp_stall = 1;
    step();
    for (int i = 0; i < 2; i++) begin
      set_wait_exp(0, F3_W, 32'h40, 32'd0);
      step();
    end
    reset = 1;
    set_wait_exp(0, F3_W, 32'h40, 32'd0);
    exp_stall = 0;
    step();
    reset = 0; ex_memread = 0; dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    set_idle_exp(); exp_zero = 1;
    step();
    dmem_ack = 0;
    set_idle_exp(); exp_zero = 1;
    step();
    $display("txn reset_mid_wait addr=0x40 -> request dropped");

    // Back-to-back: the store issues in the cycle right after the load's DONE.
    access("lh", 1, 0, F3_H, 32'h02, 32'd0, 32'h8001_0000, 0);
    check("lit_lh", cap_ld, 32'hFFFF_8001);
    access("sh", 0, 1, F3_H, 32'h00, 32'h0000_1234, 32'd0, 1);
    check("lit_sh_be", 32'(cap_be), 32'b0011);
    check("lit_sh_wdata", cap_wdata, 32'h1234_1234);
    access("sh_hi", 0, 1, F3_H, 32'h06, 32'hCAFE_5678, 32'd0, 0);
    check("lit_sh_hi_be", 32'(cap_be), 32'b1100);
    access("sw_both", 1, 1, F3_W, 32'h0C, 32'h89AB_CDEF, 32'd0, 3);
    check("lit_sw_wdata", cap_wdata, 32'h89AB_CDEF);
    access("lh_pos", 1, 0, F3_H, 32'h10, 32'd0, 32'h0000_7FFE, 0);
    check("lit_lh_pos", cap_ld, 32'h0000_7FFE);
    idle_cycle();
    idle_cycle();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
